// File: rtl/fc_neuron_mac.sv
// Streaming fixed-point MAC neuron: accumulates LANES products per chunk onto a
// bias, then rescales, saturates and optionally ReLU-clamps one SIZE-bit result.
module fc_neuron_mac #(
  parameter int SIZE      = 16,
  parameter int PRECISION = 11,
  parameter int LANES     = 4,
  parameter int CHUNK_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CHUNK_W-1:0]      num_chunks,
  input  logic [SIZE-1:0]         bias,
  input  logic                    relu_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*SIZE-1:0]   in_values,
  input  logic [LANES*SIZE-1:0]   in_weights,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SIZE-1:0]         out_value,
  output logic                    out_sat,
  output logic                    busy
);

  localparam int ACC_W  = 2*SIZE + $clog2(LANES) + CHUNK_W + 1;
  localparam int PROD_W = 2*SIZE;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SIZE+1){1'b0}}, {(SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SIZE+1){1'b1}}, {(SIZE-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_FINAL,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CHUNK_W-1:0]        cnt_q, cnt_d;
  logic                      relu_q, relu_d;
  logic signed [PROD_W-1:0]  prod_q [LANES];
  logic signed [PROD_W-1:0]  prod_d [LANES];
  logic                      prod_vld_q, prod_vld_d;
  logic [SIZE-1:0]           out_value_q, out_value_d;
  logic                      out_sat_q, out_sat_d;

  logic signed [SIZE-1:0]    val_s [LANES];
  logic signed [SIZE-1:0]    wt_s  [LANES];
  logic signed [ACC_W-1:0]   lane_sum;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   scaled;
  logic [SIZE-1:0]           res;
  logic                      res_sat;

  always_comb begin
    lane_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      val_s[i] = in_values[i*SIZE +: SIZE];
      wt_s[i]  = in_weights[i*SIZE +: SIZE];
      lane_sum = lane_sum + ACC_W'(prod_q[i]);
    end
    bias_ext = ACC_W'($signed(bias));
  end

  // Floor-shift, clamp to the SIZE range, then ReLU; saturation is flagged pre-ReLU.
  always_comb begin
    scaled  = acc_q >>> PRECISION;
    res_sat = 1'b0;
    res     = scaled[SIZE-1:0];
    if (scaled > SAT_MAX) begin
      res     = SAT_MAX[SIZE-1:0];
      res_sat = 1'b1;
    end else if (scaled < SAT_MIN) begin
      res     = SAT_MIN[SIZE-1:0];
      res_sat = 1'b1;
    end
    if (relu_q && res[SIZE-1]) begin
      res = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    relu_d      = relu_q;
    prod_d      = prod_q;
    prod_vld_d  = 1'b0;
    out_value_d = out_value_q;
    out_sat_d   = out_sat_q;

    if (prod_vld_q) begin
      acc_d = acc_q + lane_sum;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = bias_ext <<< PRECISION;
          cnt_d   = num_chunks;
          relu_d  = relu_en;
          state_d = (num_chunks != '0) ? S_ACCUM : S_FINAL;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            prod_d[i] = PROD_W'(val_s[i]) * PROD_W'(wt_s[i]);
          end
          prod_vld_d = 1'b1;
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q == CHUNK_W'(1)) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_FINAL;
      end
      S_FINAL: begin
        out_value_d = res;
        out_sat_d   = res_sat;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      relu_q      <= 1'b0;
      prod_vld_q  <= 1'b0;
      out_value_q <= '0;
      out_sat_q   <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      relu_q      <= relu_d;
      prod_vld_q  <= prod_vld_d;
      out_value_q <= out_value_d;
      out_sat_q   <= out_sat_d;
      for (int unsigned i = 0; i < LANES; i++) begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_value = out_value_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fc_neuron_mac.sv
// Directed-vector bench for fc_neuron_mac with hand-computed Q5.11 results.
module tb_fc_neuron_mac;

  localparam int SIZE      = 16;
  localparam int PRECISION = 11;
  localparam int LANES     = 4;
  localparam int CHUNK_W   = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [CHUNK_W-1:0]    num_chunks;
  logic [SIZE-1:0]       bias;
  logic                  relu_en;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*SIZE-1:0] in_values;
  logic [LANES*SIZE-1:0] in_weights;
  logic                  out_valid;
  logic                  out_ready;
  logic [SIZE-1:0]       out_value;
  logic                  out_sat;
  logic                  busy;

  int total = 0;
  int bad   = 0;

  fc_neuron_mac #(
    .SIZE(SIZE),
    .PRECISION(PRECISION),
    .LANES(LANES),
    .CHUNK_W(CHUNK_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .num_chunks(num_chunks),
    .bias(bias),
    .relu_en(relu_en),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_values(in_values),
    .in_weights(in_weights),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_value(out_value),
    .out_sat(out_sat),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a neuron, feeds nch identical chunks with 'gap' idle cycles between
  // them, and checks the exact out_valid latency and the result.
  task automatic run(input string tag, input int nch, input logic [15:0] b,
                     input logic r, input logic [63:0] v, input logic [63:0] w,
                     input int gap, input logic [15:0] exp_val, input logic exp_sat);
    start      = 1'b1;
    num_chunks = nch[CHUNK_W-1:0];
    bias       = b;
    relu_en    = r;
    tick();
    start = 1'b0;
    if (nch == 0) begin
      check_eq({tag, ".rdy_final"}, in_ready, 0);
      check_eq({tag, ".ov_early"}, out_valid, 0);
      tick();
    end else begin
      for (int c = 0; c < nch; c++) begin
        check_eq({tag, ".rdy"}, in_ready, 1);
        in_valid   = 1'b1;
        in_values  = v;
        in_weights = w;
        tick();
        in_valid = 1'b0;
        if (c != nch - 1) begin
          for (int g = 0; g < gap; g++) begin
            check_eq({tag, ".rdy_gap"}, in_ready, 1);
            tick();
          end
        end
      end
      check_eq({tag, ".rdy_flush"}, in_ready, 0);
      tick();
      check_eq({tag, ".ov_early"}, out_valid, 0);
      tick();
    end
    check_eq({tag, ".ov"}, out_valid, 1);
    check_eq({tag, ".val"}, out_value, exp_val);
    check_eq({tag, ".sat"}, out_sat, exp_sat);
    check_eq({tag, ".busy"}, busy, 1);
    check_eq({tag, ".rdy_done"}, in_ready, 0);
  endtask

  task automatic drain(input string tag, input logic start_during);
    out_ready = 1'b1;
    start     = start_during;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check_eq({tag, ".ov_after"}, out_valid, 0);
    check_eq({tag, ".busy_after"}, busy, 0);
    tick();
    check_eq({tag, ".busy_idle"}, busy, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    num_chunks = '0;
    bias       = '0;
    relu_en    = 1'b0;
    in_valid   = 1'b0;
    in_values  = '0;
    in_weights = '0;
    out_ready  = 1'b0;
    #1;
    check_eq("rst.busy", busy, 0);
    check_eq("rst.ov", out_valid, 0);
    check_eq("rst.rdy", in_ready, 0);
    check_eq("rst.val", out_value, 0);
    check_eq("rst.sat", out_sat, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // 1.0 + 4 * (1.0 * 0.5) = 3.0
    run("one", 1, 16'h0800, 1'b0, {4{16'h0800}}, {4{16'h0400}}, 0, 16'h1800, 1'b0);
    drain("one", 1'b0);
    // 3 chunks of 4 * (1.0 * -0.25) = -3.0
    run("neg", 3, 16'h0000, 1'b0, {4{16'h0800}}, {4{16'hFE00}}, 2, 16'hE800, 1'b0);
    drain("neg", 1'b0);
    run("relu", 3, 16'h0000, 1'b1, {4{16'h0800}}, {4{16'hFE00}}, 2, 16'h0000, 1'b0);
    drain("relu", 1'b0);
    run("satp", 2, 16'h7000, 1'b0, {4{16'h7FFF}}, {4{16'h7FFF}}, 0, 16'h7FFF, 1'b1);
    drain("satp", 1'b0);
    run("satn", 2, 16'h9000, 1'b0, {4{16'h7FFF}}, {4{16'h8001}}, 0, 16'h8000, 1'b1);
    drain("satn", 1'b0);
    // lanes 3..0 = 4,3,2,1 times weights -0.5,0,0,1.0 -> -1.0, plus 0.5 bias
    run("lanes", 1, 16'h0400, 1'b0, {16'h2000, 16'h1800, 16'h1000, 16'h0800},
        {16'hFC00, 16'h0000, 16'h0000, 16'h0800}, 0, 16'hFC00, 1'b0);
    drain("lanes", 1'b0);
    // raw product -1 in Q.22 floors to -1 LSB
    run("floor", 1, 16'h0000, 1'b0, {48'h0, 16'h0001}, {48'h0, 16'hFFFF}, 0, 16'hFFFF, 1'b0);
    drain("floor", 1'b0);
    run("zl", 0, 16'hF800, 1'b0, 64'h0, 64'h0, 0, 16'hF800, 1'b0);
    drain("zl", 1'b0);

    run("bp", 1, 16'h0800, 1'b0, {4{16'h0800}}, {4{16'h0400}}, 0, 16'h1800, 1'b0);
    for (int k = 0; k < 5; k++) begin
      start = (k == 0 || k == 2);
      tick();
      start = 1'b0;
      check_eq("bp.ov", out_valid, 1);
      check_eq("bp.val", out_value, 16'h1800);
      check_eq("bp.rdy", in_ready, 0);
    end
    drain("bp", 1'b1);

    // abort a 3-chunk neuron after its first chunk
    start      = 1'b1;
    num_chunks = 8'd3;
    bias       = 16'h0800;
    relu_en    = 1'b0;
    tick();
    start      = 1'b0;
    in_valid   = 1'b1;
    in_values  = {4{16'h7FFF}};
    in_weights = {4{16'h7FFF}};
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst.busy", busy, 0);
    check_eq("arst.rdy", in_ready, 0);
    check_eq("arst.ov", out_valid, 0);
    check_eq("arst.val", out_value, 0);
    check_eq("arst.sat", out_sat, 0);
    tick();
    rst_n = 1'b1;
    run("post", 1, 16'h0800, 1'b0, {4{16'h0800}}, {4{16'h0400}}, 0, 16'h1800, 1'b0);
    drain("post", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
